ttt_move_sequencer: RTL

- Match controller and move arbiter placed in front of the tic-tac-toe board storage/evaluation logic.
- Two requesters share the single board write port: the human-player input and the computer move generator. Each uses a req/ack handshake.
- The block enforces turn order, rejects illegal cells, forfeits a turn on timeout, clears the board between games, tracks scores and ends the match at a target score.

---
 rtl/ttt_move_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ttt_move_sequencer.sv
`default_nettype none
// ============================================================================
// ttt_move_sequencer : tic-tac-toe match controller and board write arbiter
// Rev 1.0
// ============================================================================
module ttt_move_sequencer #(
  parameter int WIN_TARGET   = 3,
  parameter int TURN_TIMEOUT = 200,
  parameter int TO_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       play,
  input  logic       p_req,
  input  logic [3:0] p_pos,
  output logic       p_ack,
  input  logic       c_req,
  input  logic [3:0] c_pos,
  output logic       c_ack,
  output logic [3:0] rd_pos,
  input  logic       cell_occupied,
  output logic       wr_en,
  output logic [3:0] wr_pos,
  output logic [1:0] wr_mark,
  output logic       board_clr,
  input  logic       win,
  input  logic       who,
  input  logic       no_space,
  output logic       turn,
  output logic       illegal,
  output logic       timeout,
  output logic       game_over,
  output logic [3:0] p_score,
  output logic [3:0] c_score,
  output logic       match_over
);

  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_CLEAR     = 3'd1;
  localparam logic [2:0] c_ST_P_WAIT    = 3'd2;
  localparam logic [2:0] c_ST_C_WAIT    = 3'd3;
  localparam logic [2:0] c_ST_WRITE     = 3'd4;
  localparam logic [2:0] c_ST_EVAL      = 3'd5;
  localparam logic [2:0] c_ST_DONE      = 3'd6;
  localparam logic [2:0] c_ST_MATCH_END = 3'd7;

  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TURN_TIMEOUT - 1);
  localparam logic [3:0]      c_WIN     = 4'(WIN_TARGET);
  localparam logic [1:0]      c_MARK_P  = 2'b01;
  localparam logic [1:0]      c_MARK_C  = 2'b10;

  logic [2:0]      r_state;
  logic            r_first;
  logic            r_turn;
  logic [TO_W-1:0] r_to_cnt;
  logic [3:0]      r_p_score;
  logic [3:0]      r_c_score;
  logic [3:0]      r_wr_pos;
  logic [1:0]      r_wr_mark;
  logic            r_wr_en;
  logic            r_p_ack;
  logic            r_c_ack;
  logic            r_illegal;
  logic            r_timeout;
  logic            r_board_clr;
  logic            r_game_over;
  logic            r_match_over;

  logic [2:0]      w_next;
  logic            w_req;
  logic [3:0]      w_pos;
  logic            w_pos_ok;
  logic            w_in_wait;
  logic            w_legal;
  logic            w_bad;
  logic            w_expire;
  logic            w_turn_nx;
  logic            w_first_nx;
  logic [3:0]      w_p_score_nx;
  logic [3:0]      w_c_score_nx;
  logic [3:0]      w_wr_pos_nx;
  logic [1:0]      w_wr_mark_nx;

  // Only the side to move is ever looked at; the other requester simply waits.
  assign w_req     = r_turn ? c_req : p_req;
  assign w_pos     = r_turn ? c_pos : p_pos;
  assign w_pos_ok  = (w_pos >= 4'd1) && (w_pos <= 4'd9);
  assign w_in_wait = (r_state == c_ST_P_WAIT) || (r_state == c_ST_C_WAIT);
  assign rd_pos    = w_pos;

  always_comb begin
    w_next       = r_state;
    w_legal      = 1'b0;
    w_bad        = 1'b0;
    w_expire     = 1'b0;
    w_turn_nx    = r_turn;
    w_first_nx   = r_first;
    w_p_score_nx = r_p_score;
    w_c_score_nx = r_c_score;
    w_wr_pos_nx  = r_wr_pos;
    w_wr_mark_nx = r_wr_mark;
    case (r_state)
      c_ST_IDLE: begin
        if (play) w_next = c_ST_CLEAR;
      end
      c_ST_CLEAR: begin
        w_turn_nx = r_first;
        w_next    = r_first ? c_ST_C_WAIT : c_ST_P_WAIT;
      end
      c_ST_P_WAIT, c_ST_C_WAIT: begin
        if (w_req && w_pos_ok && !cell_occupied) begin
          // A legal move beats an expiring turn in the same cycle.
          w_legal      = 1'b1;
          w_wr_pos_nx  = w_pos;
          w_wr_mark_nx = r_turn ? c_MARK_C : c_MARK_P;
          w_next       = c_ST_WRITE;
        end else begin
          w_bad = w_req;
          if (r_to_cnt == c_TO_LAST) begin
            w_expire  = 1'b1;
            w_turn_nx = ~r_turn;
            w_next    = r_turn ? c_ST_P_WAIT : c_ST_C_WAIT;
          end
        end
      end
      c_ST_WRITE: begin
        w_next = c_ST_EVAL;
      end
      c_ST_EVAL: begin
        if (win) begin
          w_next = c_ST_DONE;
          if (!who) begin
            if (r_p_score < c_WIN) w_p_score_nx = r_p_score + 4'd1;
          end else begin
            if (r_c_score < c_WIN) w_c_score_nx = r_c_score + 4'd1;
          end
        end else if (no_space) begin
          w_next = c_ST_DONE;
        end else begin
          w_turn_nx = ~r_turn;
          w_next    = r_turn ? c_ST_P_WAIT : c_ST_C_WAIT;
        end
      end
      c_ST_DONE: begin
        if ((r_p_score == c_WIN) || (r_c_score == c_WIN)) begin
          w_next = c_ST_MATCH_END;
        end else if (play) begin
          w_first_nx = ~r_first;
          w_next     = c_ST_CLEAR;
        end
      end
      c_ST_MATCH_END: begin
        if (play) begin
          w_p_score_nx = 4'd0;
          w_c_score_nx = 4'd0;
          w_first_nx   = 1'b0;
          w_next       = c_ST_CLEAR;
        end
      end
      default: begin
        w_next = c_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= c_ST_IDLE;
      r_first      <= 1'b0;
      r_turn       <= 1'b0;
      r_to_cnt     <= '0;
      r_p_score    <= 4'd0;
      r_c_score    <= 4'd0;
      r_wr_pos     <= 4'd0;
      r_wr_mark    <= 2'b00;
      r_wr_en      <= 1'b0;
      r_p_ack      <= 1'b0;
      r_c_ack      <= 1'b0;
      r_illegal    <= 1'b0;
      r_timeout    <= 1'b0;
      r_board_clr  <= 1'b0;
      r_game_over  <= 1'b0;
      r_match_over <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_first      <= w_first_nx;
      r_turn       <= w_turn_nx;
      // Counter restarts on every entry to a wait state and runs while waiting.
      r_to_cnt     <= (w_in_wait && (w_next == r_state)) ? r_to_cnt + 1'b1 : '0;
      r_p_score    <= w_p_score_nx;
      r_c_score    <= w_c_score_nx;
      r_wr_pos     <= w_wr_pos_nx;
      r_wr_mark    <= w_wr_mark_nx;
      r_wr_en      <= w_legal;
      r_p_ack      <= w_legal & ~r_turn;
      r_c_ack      <= w_legal & r_turn;
      r_illegal    <= w_bad;
      r_timeout    <= w_expire;
      r_board_clr  <= (w_next == c_ST_CLEAR);
      r_game_over  <= (w_next == c_ST_DONE) || (w_next == c_ST_MATCH_END);
      r_match_over <= (w_next == c_ST_MATCH_END);
    end
  end

  assign p_ack      = r_p_ack;
  assign c_ack      = r_c_ack;
  assign wr_en      = r_wr_en;
  assign wr_pos     = r_wr_pos;
  assign wr_mark    = r_wr_mark;
  assign board_clr  = r_board_clr;
  assign turn       = r_turn;
  assign illegal    = r_illegal;
  assign timeout    = r_timeout;
  assign game_over  = r_game_over;
  assign p_score    = r_p_score;
  assign c_score    = r_c_score;
  assign match_over = r_match_over;

endmodule
`default_nettype wire
